// File: rtl/apb_wdt_pkg.sv
// Shared constants for the multi-channel APB watchdog: register map, keys and
// CTRL/STAT bit positions.
package apb_wdt_pkg;

  localparam logic [1:0]  CNT_OFF      = 2'd0;
  localparam logic [1:0]  LOAD_OFF     = 2'd1;
  localparam logic [1:0]  CTRL_OFF     = 2'd2;
  localparam logic [1:0]  STAT_OFF     = 2'd3;

  localparam logic [17:0] IRQEN_ADDR   = 18'h40;
  localparam logic [17:0] IRQSTAT_ADDR = 18'h41;
  localparam logic [17:0] ID_ADDR      = 18'h42;

  localparam logic [31:0] KICK_KEY     = 32'h5A5A_A5A5;
  localparam logic [31:0] DEAD_VAL     = 32'hDEAD_BEEF;

  // Top byte of the ID register: ASCII 'W' for watchdog.
  localparam logic [7:0]  ID_TAG       = 8'h57;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RSTEN_BIT  = 1;
  localparam int CTRL_PRESC_LSB  = 8;
  localparam int STAT_OV_BIT     = 0;
  localparam int STAT_RSTREQ_BIT = 1;

  function automatic logic [31:0] make_id(input int nch, input int cw, input int pw);
    return {ID_TAG, 8'(nch), 8'(cw), 8'(pw)};
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: prescaler, down-counter, overflow flag and sticky
// reset-request flag.
module wdt_channel #(
  parameter int CW = 32,
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CW-1:0] load_i,
  input  logic [PW+1:0] ctrl_i,    // {presc, rsten, en}
  input  logic          kick_i,
  input  logic          ov_clr_i,
  input  logic          en_rise_i,
  output logic [CW-1:0] cnt_o,
  output logic          ov_o,
  output logic          rstreq_o
);

  logic          en;
  logic          rsten;
  logic [PW-1:0] presc;
  logic          tick;
  logic          reload;
  logic          timeout;

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic          rstreq_q, rstreq_d;

  assign en      = ctrl_i[0];
  assign rsten   = ctrl_i[1];
  assign presc   = ctrl_i[PW+1:2];
  assign tick    = en && (presc_cnt_q == presc);
  assign reload  = en_rise_i || kick_i;
  // A reload on the same edge suppresses the timeout and its flag updates.
  assign timeout = tick && (cnt_q == '0) && !reload;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    ov_d        = ov_q;
    rstreq_d    = rstreq_q;
    if (reload) begin
      presc_cnt_d = '0;
      cnt_d       = load_i;
    end else if (en) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) begin
        cnt_d = (cnt_q == '0) ? load_i : cnt_q - 1'b1;
      end
    end
    // Setting OV wins over a same-cycle W1C; RSTREQ looks at the pre-edge OV.
    if (timeout) begin
      ov_d = 1'b1;
      if (ov_q && rsten) begin
        rstreq_d = 1'b1;
      end
    end else if (ov_clr_i) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      ov_q        <= 1'b0;
      rstreq_q    <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      ov_q        <= ov_d;
      rstreq_q    <= rstreq_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign ov_o     = ov_q;
  assign rstreq_o = rstreq_q;

endmodule

// File: rtl/apb_wdt_multi.sv
// APB watchdog with NCH independent channels: register decode, IRQ enable,
// read mux and the channel array.
module apb_wdt_multi
  import apb_wdt_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = 32,
  parameter int PW  = 8
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           PSEL,
  input  logic [19:2]    PADDR,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           IRQ,
  output logic [NCH-1:0] IRQ_VEC,
  output logic           RST_REQ
);

  logic           wr_en;
  logic [1:0]     reg_off;
  logic [NCH-1:0] ch_sel;
  logic [NCH-1:0] kick, ov_clr, en_rise;

  logic [CW-1:0]  load_q [NCH];
  logic [PW-1:0]  presc_q [NCH];
  logic [NCH-1:0] en_q, rsten_q;
  logic [NCH-1:0] irqen_q;

  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] ov, rstreq;

  assign wr_en   = PSEL && PWRITE && PENABLE;
  assign reg_off = PADDR[3:2];
  assign PREADY  = 1'b1;

  // Word address bits above the offset select a channel; indices >= NCH never match.
  always_comb begin
    ch_sel  = '0;
    kick    = '0;
    ov_clr  = '0;
    en_rise = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_sel[c] = (PADDR[19:4] == 16'(c));
      if (wr_en && ch_sel[c]) begin
        kick[c]    = (reg_off == CNT_OFF) && (PWDATA == KICK_KEY);
        ov_clr[c]  = (reg_off == STAT_OFF) && PWDATA[STAT_OV_BIT];
        en_rise[c] = (reg_off == CTRL_OFF) && PWDATA[CTRL_EN_BIT] && !en_q[c];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int c = 0; c < NCH; c++) begin
        load_q[c]  <= '0;
        presc_q[c] <= '0;
      end
      en_q    <= '0;
      rsten_q <= '0;
      irqen_q <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_sel[c]) begin
          case (reg_off)
            LOAD_OFF: load_q[c] <= PWDATA[CW-1:0];
            CTRL_OFF: begin
              en_q[c]    <= PWDATA[CTRL_EN_BIT];
              rsten_q[c] <= PWDATA[CTRL_RSTEN_BIT];
              presc_q[c] <= PWDATA[CTRL_PRESC_LSB +: PW];
            end
            default: ;
          endcase
        end
      end
      if (PADDR == IRQEN_ADDR) begin
        irqen_q <= PWDATA[NCH-1:0];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wdt_channel #(
      .CW (CW),
      .PW (PW)
    ) u_chan (
      .clk_i     (PCLK),
      .rst_i     (PRESET),
      .load_i    (load_q[c]),
      .ctrl_i    ({presc_q[c], rsten_q[c], en_q[c]}),
      .kick_i    (kick[c]),
      .ov_clr_i  (ov_clr[c]),
      .en_rise_i (en_rise[c]),
      .cnt_o     (cnt[c]),
      .ov_o      (ov[c]),
      .rstreq_o  (rstreq[c])
    );
  end

  assign IRQ_VEC = ov & irqen_q;
  assign IRQ     = |IRQ_VEC;
  assign RST_REQ = |rstreq;

  always_comb begin
    PRDATA = DEAD_VAL;
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel[c]) begin
        PRDATA = '0;
        case (reg_off)
          CNT_OFF:  PRDATA[CW-1:0] = cnt[c];
          LOAD_OFF: PRDATA[CW-1:0] = load_q[c];
          CTRL_OFF: begin
            PRDATA[CTRL_EN_BIT]            = en_q[c];
            PRDATA[CTRL_RSTEN_BIT]         = rsten_q[c];
            PRDATA[CTRL_PRESC_LSB +: PW]   = presc_q[c];
          end
          default: begin
            PRDATA[STAT_OV_BIT]     = ov[c];
            PRDATA[STAT_RSTREQ_BIT] = rstreq[c];
          end
        endcase
      end
    end
    if (PADDR == IRQEN_ADDR) begin
      PRDATA = 32'(irqen_q);
    end else if (PADDR == IRQSTAT_ADDR) begin
      PRDATA = 32'(IRQ_VEC);
    end else if (PADDR == ID_ADDR) begin
      PRDATA = make_id(NCH, CW, PW);
    end
  end

endmodule
